// File: rtl/rr_arbiter_4_if.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4_if
//
// Purpose: bundles the request/grant handshake of the four-requester
// round-robin arbiter so that requesters and the arbiter connect through a
// single port.
//
// Signals:
//   req           [3:0]  request vector, bit i = requester i wants ownership
//   grant         [3:0]  registered grant, 0000 or one-hot
//   grant_valid          registered, equals |grant
//   grant_expired        registered one-cycle pulse after a forced release
//
// Modports:
//   master : requester side (drives req, observes grant outputs)
//   slave  : arbiter side   (observes req, drives grant outputs)
// ----------------------------------------------------------------------------
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic       grant_expired;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_expired
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_expired
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// ----------------------------------------------------------------------------
// rr_arbiter_4
//
// Purpose: four-requester round-robin arbiter with a registered one-hot
// grant and a bounded hold time. The grant feeds a 4-to-2 encoder directly,
// so it is only ever 0000 or one-hot.
//
// Parameters:
//   MAX_HOLD  maximum consecutive cycles one owner keeps the grant while
//             others wait (legal range 1..255)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter_4_if.slave:
//            req (in), grant / grant_valid / grant_expired (out, registered)
//
// There is no combinational path from req to any output.
// ----------------------------------------------------------------------------
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_arbiter_4_if.slave   bus
);

    localparam int              CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Round-robin scan: ptr, ptr+1, ... wrapping mod 4; first set bit wins.
    function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] start);
        pick_t      res;
        logic [1:0] idx;
        res = '0;
        for (int k = 0; k < 4; k++) begin
            idx = start + k[1:0];
            if (!res.found && r[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot_of(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    state_t           state_q,   state_d;
    logic [1:0]       owner_q,   owner_d;
    logic [1:0]       ptr_q,     ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]       grant_q,   grant_d;
    logic             valid_q;
    logic             expired_q, expired_d;

    logic [3:0]       req_masked;
    pick_t            win_all;
    pick_t            win_masked;

    // The owner's own bit is removed so a release always prefers someone else.
    assign req_masked = bus.req & ~onehot_of(owner_q);
    assign win_all    = rr_pick(bus.req, ptr_q);
    assign win_masked = rr_pick(req_masked, ptr_q);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        expired_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_all.found) begin
                    state_d    = GRANT;
                    owner_d    = win_all.idx;
                    grant_d    = onehot_of(win_all.idx);
                    hold_cnt_d = CNT_ONE;
                    ptr_d      = win_all.idx + 2'd1;
                end else begin
                    grant_d    = 4'b0000;
                end
            end

            GRANT: begin
                if (!bus.req[owner_q]) begin
                    // Voluntary release: hand off back-to-back or fall idle.
                    if (win_masked.found) begin
                        owner_d    = win_masked.idx;
                        grant_d    = onehot_of(win_masked.idx);
                        hold_cnt_d = CNT_ONE;
                        ptr_d      = win_masked.idx + 2'd1;
                    end else begin
                        state_d    = IDLE;
                        grant_d    = 4'b0000;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q == HOLD_MAX) begin
                    // Forced release; a lone owner is simply re-granted.
                    expired_d = 1'b1;
                    if (win_masked.found) begin
                        owner_d    = win_masked.idx;
                        grant_d    = onehot_of(win_masked.idx);
                        hold_cnt_d = CNT_ONE;
                        ptr_d      = win_masked.idx + 2'd1;
                    end else begin
                        hold_cnt_d = CNT_ONE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            grant_q    <= 4'b0000;
            valid_q    <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            valid_q    <= |grant_d;
            expired_q  <= expired_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.grant_valid   = valid_q;
    assign bus.grant_expired = expired_q;

    // Downstream encoder produces xx on multi-hot input.
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant_q));

    a_valid_matches : assert property (@(posedge clk) disable iff (!rst_n)
        valid_q == (|grant_q));

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter with a registered one-hot grant and a bounded hold time. It sits directly upstream of the `encoder_4x2` stage: `grant` drives the encoder's `in`, and the encoder converts it to a 2-bit owner index. `grant` is therefore guaranteed to be all-zero or exactly one-hot, never multi-hot. The encoder outputs `xx` on any multi-hot input.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may own the grant while others wait. Legal range 1..255.
- `clk` input 1: sole clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 4: request vector; bit i high means requester i wants ownership. Any pattern is legal.
- `grant` output 4: registered grant, `0000` or one-hot.
- `grant_valid` output 1: registered; always equals `|grant`.
- `grant_expired` output 1: registered one-cycle pulse; high in the first cycle after a forced (`MAX_HOLD`) release.

## Operation
- Internal state:
  - `state` ∈ {IDLE, GRANT}.
  - `owner[1:0]`.
  - `ptr[1:0]`: highest-priority requester for the next arbitration.
  - `hold_cnt`: width `$clog2(MAX_HOLD+1)`.
- Arbitration function: scan `req` starting at `ptr`, in the order `ptr`, `ptr+1`, …, wrapping mod 4 (3→0). The first set bit wins.
- IDLE:
  - `req == 0000`: stay in IDLE, `grant = 0000`.
  - Otherwise: arbitrate. Winner w becomes owner, `grant <= 1<<w`, `hold_cnt <= 1`, `ptr <= w+1 mod 4`, go to GRANT.
- GRANT, evaluated each edge in priority order:
  1. `req[owner] == 0` (voluntary release): arbitrate over `req` with the owner bit masked. If there is a winner, hand off directly in the same edge with no idle cycle (`hold_cnt <= 1`, `ptr` updated). If there is none, go to IDLE with `grant <= 0000`. `grant_expired <= 0`.
  2. `req[owner] == 1` and `hold_cnt == MAX_HOLD` (forced release): arbitrate with the owner bit masked.
     - Winner exists: hand off as above.
     - No winner: the owner is re-granted, `grant` is unchanged and `hold_cnt <= 1`.
     - In both cases `grant_expired <= 1`.
  3. Otherwise: `hold_cnt <= hold_cnt + 1`, `grant` unchanged, `grant_expired <= 0`.
- `ptr` is updated only when a grant is issued or handed off, never while a grant is held.
- `req` bits for non-owners have no effect during GRANT except through the arbitration at release.
- Reset values: `grant = 0000`, `grant_valid = 0`, `grant_expired = 0`, `state = IDLE`, `ptr = 0`, `hold_cnt = 0`, `owner = 0`.

## Timing
- Request to grant latency: `req` sampled at edge N produces `grant` valid after edge N (1 cycle). There is no combinational path from `req` to any output.
- Release latency: the owner dropping `req` before edge N means `grant` changes at edge N. The grant remains visible for the cycle in which `req` was low.
- A requester holds the grant for at most `MAX_HOLD` consecutive cycles when others are waiting. Worst-case wait for a requester is 3×`MAX_HOLD` cycles.
- Handoff is back-to-back: `grant` goes directly from one-hot to one-hot with no `0000` cycle, so `grant_valid` stays high.
- `grant_expired` is coincident with the first cycle of the new (or re-granted) ownership and lasts exactly 1 cycle.
- Asynchronous reset: `rst_n` falling forces all outputs to their reset values immediately, without a clock edge, including mid-grant. On deassertion, arbitration resumes at the next rising edge with `ptr = 0`.
- `MAX_HOLD = 1`: every owning cycle is a forced release, and `grant_expired` stays high continuously under contention.

## Test plan
- Reset: assert `rst_n = 0` with `req = 1111` → `grant = 0000`, `grant_valid = 0`, `grant_expired = 0` with no clock. Deassert with `req = 0000` for 5 cycles → outputs unchanged.
- Single requester: `req = 0100` from IDLE → `grant = 0100` after 1 edge. Then `req = 0000` → `grant = 0000`, `grant_valid = 0` after the next edge.
- Rotation and wrap with `MAX_HOLD = 2` and `req = 1111` held → `grant` sequence `0001`×2, `0010`×2, `0100`×2, `1000`×2, `0001`…. `grant_expired` pulses in the first cycle of each new grant. Feeding `grant` into `encoder_4x2` yields `out` 00, 01, 10, 11, 00.
- Voluntary handoff with `req = 0011` and owner 0: drop `req[0]` → `grant = 0010` next cycle, `grant_valid` never 0, `grant_expired = 0`.
- Lone requester with `MAX_HOLD = 4` and `req = 1000` for 12 cycles → `grant` stays `1000` throughout, and `grant_expired` pulses every 4th cycle (3 pulses).
- Mid-grant reset: owner 2 holding the grant, pulse `rst_n` low between edges → `grant = 0000` at once. After release, `req = 1001` → `grant = 0001` (`ptr` back to 0).
- All scenarios: assert every cycle that `grant` is `0000` or one-hot and that `grant_valid == |grant`.
